// File: rtl/led_sr_out.sv
// rtl/led_sr_out.sv - serialiser from the blinker LED word to a 74HC595-style shift register
//
// Accepts one WIDTH-bit word on sr_go && sr_rdy, shifts it MSB first on
// led_sdata/led_sclk, then pulses led_slatch so the external outputs update.
// Every output is a register, so the board sees no combinational glitches.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   sr_val      parallel LED word, sampled only when a transfer is accepted
//   sr_go       transfer request level from the blinker
//   sr_rdy      high only while idle; acceptance is sr_go && sr_rdy
//   led_sdata   serial data, stable for the whole bit
//   led_sclk    shift clock, external register samples on its rising edge
//   led_slatch  storage latch pulse, external outputs update on its rising edge

module led_sr_out #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sr_val,
    input  logic             sr_go,
    output logic             sr_rdy,
    output logic             led_sdata,
    output logic             led_sclk,
    output logic             led_slatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [WIDTH-1:0] shreg, shreg_n, shreg_sh;
    logic             rdy_n, sdata_n, sclk_n, slatch_n;

    assign shreg_sh = shreg << 1;

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so each value below is what the pins show next cycle.
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        rdy_n    = sr_rdy;
        sdata_n  = led_sdata;
        sclk_n   = led_sclk;
        slatch_n = led_slatch;

        unique case (state)
            IDLE: begin
                if (sr_go) begin
                    state_n = SHIFT;
                    shreg_n = sr_val;
                    sdata_n = sr_val[WIDTH-1];
                    sclk_n  = 1'b0;
                    div_n   = '0;
                    bit_n   = '0;
                    rdy_n   = 1'b0;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (!led_sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        // End of a bit's high phase: either move to the next
                        // bit (new data with sclk low) or finish with the latch.
                        sclk_n = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n  = LATCH;
                            slatch_n = 1'b1;
                        end else begin
                            bit_n   = bit_cnt + 1'b1;
                            shreg_n = shreg_sh;
                            sdata_n = shreg_sh[WIDTH-1];
                        end
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (div_cnt == DIV_LAST) begin
                    state_n  = IDLE;
                    div_n    = '0;
                    slatch_n = 1'b0;
                    sdata_n  = 1'b0;
                    rdy_n    = 1'b1;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                div_n    = '0;
                bit_n    = '0;
                rdy_n    = 1'b1;
                sdata_n  = 1'b0;
                sclk_n   = 1'b0;
                slatch_n = 1'b0;
            end
        endcase
    end

    // Reset also covers an abort mid-transfer: no latch pulse is emitted, so
    // the LEDs keep the last fully latched word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sr_rdy     <= 1'b1;
            led_sdata  <= 1'b0;
            led_sclk   <= 1'b0;
            led_slatch <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            sr_rdy     <= rdy_n;
            led_sdata  <= sdata_n;
            led_sclk   <= sclk_n;
            led_slatch <= slatch_n;
        end
    end

endmodule

// File: tb/tb_led_sr_out.sv
// tb/tb_led_sr_out.sv - directed self-checking bench for led_sr_out

module tb_led_sr_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default WIDTH=8, CLK_DIV=2
    logic       rst_a, sr_go_a, sr_rdy_a, led_sdata_a, led_sclk_a, led_slatch_a;
    logic [7:0] sr_val_a;
    // Instance B: WIDTH=4, CLK_DIV=1
    logic       rst_b, sr_go_b, sr_rdy_b, led_sdata_b, led_sclk_b, led_slatch_b;
    logic [3:0] sr_val_b;

    led_sr_out #(.WIDTH(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst_a), .sr_val(sr_val_a), .sr_go(sr_go_a),
        .sr_rdy(sr_rdy_a), .led_sdata(led_sdata_a), .led_sclk(led_sclk_a),
        .led_slatch(led_slatch_a)
    );

    led_sr_out #(.WIDTH(4), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .sr_val(sr_val_b), .sr_go(sr_go_b),
        .sr_rdy(sr_rdy_b), .led_sdata(led_sdata_b), .led_sclk(led_sclk_b),
        .led_slatch(led_slatch_b)
    );

    logic [3:0] bundle_a, bundle_b;
    assign bundle_a = {sr_rdy_a, led_sdata_a, led_sclk_a, led_slatch_a};
    assign bundle_b = {sr_rdy_b, led_sdata_b, led_sclk_b, led_slatch_b};

    // External 74HC595 models: shift on sclk rise, latch on slatch rise.
    logic [7:0] ext_sr_a, ext_q_a;
    logic [3:0] ext_sr_b, ext_q_b;
    int latch_cnt_a = 0;
    int latch_cnt_b = 0;

    always @(posedge led_sclk_a) ext_sr_a <= {ext_sr_a[6:0], led_sdata_a};
    always @(posedge led_slatch_a) begin
        ext_q_a     <= ext_sr_a;
        latch_cnt_a <= latch_cnt_a + 1;
    end
    always @(posedge led_sclk_b) ext_sr_b <= {ext_sr_b[2:0], led_sdata_b};
    always @(posedge led_slatch_b) begin
        ext_q_b     <= ext_sr_b;
        latch_cnt_b <= latch_cnt_b + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {rdy, sdata, sclk, slatch} in cycle T+c of a transfer accepted at T.
    function automatic logic [3:0] exp_bundle(int c, int cd, int w, logic [7:0] word);
        int p;
        int i;
        int ph;
        p = 2 * cd;
        if (c <= p * w) begin
            i  = (c - 1) / p;
            ph = (c - 1) % p;
            return {1'b0, word[w-1-i], (ph >= cd), 1'b0};
        end else if (c <= p * w + cd) begin
            return {1'b0, word[0], 1'b0, 1'b1};
        end
        return 4'b1000;
    endfunction

    // One transfer on instance A starting in the current (idle) cycle T.
    // chg_c: cycle offset at which sr_val is changed to chg_v (-1: never).
    // rst_c: cycle offset at which rst is raised to abort (-1: never).
    task automatic run_a(input logic [7:0] v, input bit hold, input int chg_c,
                         input logic [7:0] chg_v, input int rst_c);
        int lc;
        lc       = latch_cnt_a;
        sr_val_a = v;
        sr_go_a  = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            if (c - 1 == chg_c) sr_val_a = chg_v;
            if (c - 1 == rst_c) rst_a = 1'b1;
            tick();
            if (c == 1 && !hold) sr_go_a = 1'b0;
            if (rst_a) begin
                chk($sformatf("abort_idle_%0h_c%0d", v, c), bundle_a, 4'b1000);
                chk($sformatf("abort_nolatch_%0h", v), latch_cnt_a, lc);
                rst_a   = 1'b0;
                sr_go_a = 1'b0;
                return;
            end
            chk($sformatf("xfer_%0h_c%0d", v, c), bundle_a, exp_bundle(c, 2, 8, v));
        end
        chk($sformatf("latched_%0h", v), ext_q_a, v);
        chk($sformatf("latch_pulses_%0h", v), latch_cnt_a, lc + 1);
    endtask

    initial begin
        int lc0;
        rst_a = 1'b1; sr_go_a = 1'b0; sr_val_a = 8'h00;
        rst_b = 1'b1; sr_go_b = 1'b0; sr_val_b = 4'h0;
        tick();
        tick();
        chk("reset_a", bundle_a, 4'b1000);
        chk("reset_b", bundle_b, 4'b1000);
        rst_a = 1'b0;

        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("idle_c%0d", k), bundle_a, 4'b1000);
        end

        run_a(8'hA5, 1'b0, -1, 8'h00, -1);

        // Reset and request in the same cycle: reset wins.
        lc0 = latch_cnt_a;
        rst_a = 1'b1; sr_go_a = 1'b1; sr_val_a = 8'h5A;
        tick();
        chk("rst_go_c1", bundle_a, 4'b1000);
        rst_a = 1'b0; sr_go_a = 1'b0;
        tick();
        chk("rst_go_c2", bundle_a, 4'b1000);
        chk("rst_go_nolatch", latch_cnt_a, lc0);

        // Continuous request: FF then 00; the 00 must wait for the idle cycle.
        run_a(8'hFF, 1'b1, 5, 8'h00, -1);
        run_a(8'h00, 1'b0, -1, 8'h00, -1);

        // sr_val change mid-transfer has no effect.
        run_a(8'hC3, 1'b0, 10, 8'h00, -1);

        // Abort mid-shift; visible LEDs keep C3, then a clean 3C transfer.
        run_a(8'hE7, 1'b0, -1, 8'h00, 12);
        chk("abort_keeps_q", ext_q_a, 8'hC3);
        tick();
        chk("after_abort_idle", bundle_a, 4'b1000);
        run_a(8'h3C, 1'b0, -1, 8'h00, -1);

        // Instance B: WIDTH=4, CLK_DIV=1, word 9.
        rst_b = 1'b0;
        tick();
        chk("idle_b", bundle_b, 4'b1000);
        sr_val_b = 4'h9;
        sr_go_b  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) sr_go_b = 1'b0;
            chk($sformatf("xfer_b_c%0d", c), bundle_b, exp_bundle(c, 1, 4, 8'h09));
        end
        chk("latched_b", ext_q_b, 4'h9);
        chk("latch_pulses_b", latch_cnt_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
